// File: rtl/ds2411_responder.sv
// ds2411_responder: 1-Wire slave that answers a master reset with a
// presence pulse, takes one command byte and, on Read ROM (33h/0Fh),
// returns FAMILY, the 48-bit serial and a CRC8 built while the bits go out.
module ds2411_responder #(
    parameter int unsigned CLK_MHZ    = 100,
    parameter logic [7:0]  FAMILY     = 8'h01,
    parameter int unsigned RST_MIN_US = 400,
    parameter int unsigned PD_WAIT_US = 30,
    parameter int unsigned PD_LOW_US  = 120,
    parameter int unsigned SAMPLE_US  = 30,
    parameter int unsigned HOLD0_US   = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dq_in,
    output logic        dq_oe,
    input  logic [47:0] serial,
    output logic        presence,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        rom_done,
    output logic        busy,
    output logic        error
);

    localparam int unsigned CW = $clog2(1000 * CLK_MHZ);
    localparam logic [CW-1:0] CNT_MAX      = '1;
    localparam logic [CW-1:0] RST_CYC      = CW'(RST_MIN_US * CLK_MHZ);
    localparam logic [CW-1:0] PD_WAIT_LAST = CW'(PD_WAIT_US * CLK_MHZ - 1);
    localparam logic [CW-1:0] PD_LOW_LAST  = CW'(PD_LOW_US * CLK_MHZ - 1);
    localparam logic [CW-1:0] SAMPLE_LAST  = CW'(SAMPLE_US * CLK_MHZ - 1);
    localparam logic [CW-1:0] HOLD0_LAST   = CW'(HOLD0_US * CLK_MHZ - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PD_WAIT, S_PD_LOW, S_CMD_WAIT, S_CMD_SAMPLE,
        S_CMD_REC, S_ROM_WAIT, S_ROM_DRIVE, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q, dqs_prev_q;
    logic [CW-1:0]   low_cnt_q;
    logic [CW-1:0]   timer_q, timer_d;
    logic [5:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      cmd_sr_q, cmd_sr_d;
    logic [7:0]      cmd_byte_q, cmd_byte_d;
    logic [7:0]      crc_q, crc_d;
    logic            error_q, error_d;
    logic            dq_oe_q, dq_oe_d;
    logic            presence_q, presence_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            rom_done_q, rom_done_d;

    logic            dqs, dq_fall, dq_rise, bus_rst;
    logic            rom_bit, crc_fb;
    logic [5:0]      ser_idx;
    logic [7:0]      crc_next;

    assign dqs     = sync2_q;
    assign dq_fall = dqs_prev_q & ~dqs;
    assign dq_rise = ~dqs_prev_q & dqs;
    assign bus_rst = dq_rise && (low_cnt_q >= RST_CYC);

    // Two-flop synchroniser plus a delayed copy for edge detection; idles high like the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            dqs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= dq_in;
            sync2_q    <= sync1_q;
            dqs_prev_q <= sync2_q;
        end
    end

    // Master low-time counter; our own drive is excluded so it cannot fake a reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            low_cnt_q <= '0;
        end else if (dqs) begin
            low_cnt_q <= '0;
        end else if (!dq_oe_q && (low_cnt_q != CNT_MAX)) begin
            low_cnt_q <= low_cnt_q + 1'b1;
        end
    end

    // ROM bit mux and the CRC step it feeds (bit 56 onward reads the finished CRC).
    always_comb begin
        ser_idx = bit_idx_q - 6'd8;
        if (bit_idx_q < 6'd8) begin
            rom_bit = FAMILY[bit_idx_q[2:0]];
        end else if (bit_idx_q < 6'd56) begin
            rom_bit = serial[ser_idx];
        end else begin
            rom_bit = crc_q[bit_idx_q[2:0]];
        end
        crc_fb   = crc_q[0] ^ rom_bit;
        crc_next = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            cmd_sr_q    <= '0;
            cmd_byte_q  <= '0;
            crc_q       <= '0;
            error_q     <= 1'b0;
            dq_oe_q     <= 1'b0;
            presence_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            rom_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            cmd_sr_q    <= cmd_sr_d;
            cmd_byte_q  <= cmd_byte_d;
            crc_q       <= crc_d;
            error_q     <= error_d;
            dq_oe_q     <= dq_oe_d;
            presence_q  <= presence_d;
            cmd_valid_q <= cmd_valid_d;
            rom_done_q  <= rom_done_d;
        end
    end

    // Next-state logic; a bus reset overrides whatever transfer is in progress.
    always_comb begin
        state_d     = state_q;
        timer_d     = (timer_q == CNT_MAX) ? timer_q : timer_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        cmd_sr_d    = cmd_sr_q;
        cmd_byte_d  = cmd_byte_q;
        crc_d       = crc_q;
        error_d     = error_q;
        dq_oe_d     = 1'b0;
        presence_d  = 1'b0;
        cmd_valid_d = 1'b0;
        rom_done_d  = 1'b0;
        if (bus_rst) begin
            state_d   = S_PD_WAIT;
            timer_d   = '0;
            bit_idx_d = '0;
            crc_d     = '0;
            error_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_HALT: begin
                end
                S_PD_WAIT: begin
                    if (timer_q == PD_WAIT_LAST) begin
                        state_d = S_PD_LOW;
                        timer_d = '0;
                        dq_oe_d = 1'b1;
                    end
                end
                S_PD_LOW: begin
                    if (timer_q == PD_LOW_LAST) begin
                        state_d    = S_CMD_WAIT;
                        presence_d = 1'b1;
                        bit_idx_d  = '0;
                    end else begin
                        dq_oe_d = 1'b1;
                    end
                end
                S_CMD_WAIT: begin
                    if (dq_fall) begin
                        state_d = S_CMD_SAMPLE;
                        timer_d = '0;
                    end
                end
                S_CMD_SAMPLE: begin
                    if (timer_q == SAMPLE_LAST) begin
                        cmd_sr_d = {dqs, cmd_sr_q[7:1]};
                        state_d  = S_CMD_REC;
                    end
                end
                S_CMD_REC: begin
                    if (dqs) begin
                        if (bit_idx_q == 6'd7) begin
                            cmd_valid_d = 1'b1;
                            cmd_byte_d  = cmd_sr_q;
                            bit_idx_d   = '0;
                            if ((cmd_sr_q == 8'h33) || (cmd_sr_q == 8'h0F)) begin
                                state_d = S_ROM_WAIT;
                            end else begin
                                error_d = 1'b1;
                                state_d = S_HALT;
                            end
                        end else begin
                            bit_idx_d = bit_idx_q + 6'd1;
                            state_d   = S_CMD_WAIT;
                        end
                    end
                end
                S_ROM_WAIT: begin
                    if (dq_fall) begin
                        state_d = S_ROM_DRIVE;
                        timer_d = '0;
                        dq_oe_d = ~rom_bit;
                    end
                end
                S_ROM_DRIVE: begin
                    // Drive window is fixed from the edge; only after it do we look for release.
                    if (timer_q < HOLD0_LAST) begin
                        dq_oe_d = ~rom_bit;
                    end else if (dqs) begin
                        if (bit_idx_q < 6'd56) begin
                            crc_d = crc_next;
                        end
                        if (bit_idx_q == 6'd63) begin
                            rom_done_d = 1'b1;
                            state_d    = S_HALT;
                        end else begin
                            bit_idx_d = bit_idx_q + 6'd1;
                            state_d   = S_ROM_WAIT;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign dq_oe     = dq_oe_q;
    assign presence  = presence_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_byte  = cmd_byte_q;
    assign rom_done  = rom_done_q;
    assign error     = error_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_ds2411_responder.sv
// Directed-plus-random bench for ds2411_responder acting as a 1-Wire master.
// Runs at CLK_MHZ = 1 so one microsecond is one clock.
module tb_ds2411_responder;

    localparam int unsigned CLK_MHZ     = 1;
    localparam logic [7:0]  FAMILY      = 8'h02;
    localparam int          PD_WAIT_CYC = 30 * CLK_MHZ;
    localparam int          PD_LOW_CYC  = 120 * CLK_MHZ;
    localparam int          HOLD0_CYC   = 30 * CLK_MHZ;

    logic        clk = 1'b0;
    logic        reset;
    logic        dq_in;
    logic        dq_oe;
    logic [47:0] serial;
    logic        presence, cmd_valid, rom_done, busy, error;
    logic [7:0]  cmd_byte;
    logic        master_low;

    int checks = 0;
    int failures = 0;
    int presence_cnt = 0;
    int cmd_valid_cnt = 0;
    int rom_done_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] valid_cmd = 8'h00;

    always #5 clk = ~clk;

    // Open-drain bus: low if either side pulls.
    assign dq_in = ~(master_low | dq_oe);

    ds2411_responder #(
        .CLK_MHZ(CLK_MHZ), .FAMILY(FAMILY), .RST_MIN_US(400), .PD_WAIT_US(30),
        .PD_LOW_US(120), .SAMPLE_US(30), .HOLD0_US(30)
    ) dut (
        .clk(clk), .reset(reset), .dq_in(dq_in), .dq_oe(dq_oe), .serial(serial),
        .presence(presence), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
        .rom_done(rom_done), .busy(busy), .error(error)
    );

    // Pulse and drive monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (presence)  presence_cnt  <= presence_cnt + 1;
        if (cmd_valid) begin
            cmd_valid_cnt <= cmd_valid_cnt + 1;
            valid_cmd     <= cmd_byte;
        end
        if (rom_done)  rom_done_cnt  <= rom_done_cnt + 1;
        if (dq_oe)     oe_cnt        <= oe_cnt + 1;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference ROM: family, serial, then the Dallas CRC of those seven bytes.
    function automatic logic [63:0] model_rom(input logic [7:0] fam, input logic [47:0] ser);
        logic [7:0] bytes [7];
        logic [7:0] crc;
        bytes[0] = fam;
        for (int i = 0; i < 6; i++) bytes[i+1] = ser[8*i +: 8];
        crc = 8'h00;
        for (int i = 0; i < 7; i++) begin
            crc = crc ^ bytes[i];
            for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 8'h8C) : (crc >> 1);
        end
        return {crc, ser, fam};
    endfunction

    task automatic write_bit(input logic b);
        int lo, len;
        lo  = b ? $urandom_range(2, 10) : $urandom_range(60, 65);
        len = $urandom_range(72, 80);
        master_low = 1'b1;
        tick(lo);
        master_low = 1'b0;
        tick(len - lo);
    endtask

    task automatic read_bit(output logic b, output int hc);
        int lo, len;
        lo  = $urandom_range(2, 6);
        len = $urandom_range(72, 80);
        hc  = 0;
        b   = 1'b1;
        for (int c = 0; c < len; c++) begin
            master_low = (c < lo);
            tick();
            if (c == 14) b = dq_in;
            if (dq_oe) hc++;
        end
        master_low = 1'b0;
    endtask

    task automatic read_rom(input int n, output logic [63:0] r, output int bad);
        logic b;
        int   hc;
        r   = '0;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            read_bit(b, hc);
            r[i] = b;
            if (hc != (b ? 0 : HOLD0_CYC)) bad++;
        end
    endtask

    task automatic presence_seq(input string tag);
        int k, w, p0;
        p0 = presence_cnt;
        master_low = 1'b1;
        tick(480 + $urandom_range(0, 20));
        master_low = 1'b0;
        k = 0;
        while (!dq_oe && k < 200) begin tick(); k++; end
        chk({tag, "_pd_start"}, 64'((k >= PD_WAIT_CYC) && (k <= PD_WAIT_CYC + 4)), 64'd1);
        w = 0;
        while (dq_oe && w < 400) begin tick(); w++; end
        chk({tag, "_pd_width"}, 64'(w), 64'(PD_LOW_CYC));
        tick(4);
        chk({tag, "_presence_pulses"}, 64'(presence_cnt - p0), 64'd1);
        chk({tag, "_busy_cmd_wait"}, 64'(busy), 64'd1);
        chk({tag, "_error_cleared"}, 64'(error), 64'd0);
        tick(10);
    endtask

    task automatic cmd_seq(input string tag, input logic [7:0] cmd);
        int   c0;
        logic bad_cmd;
        c0 = cmd_valid_cnt;
        for (int i = 0; i < 8; i++) write_bit(cmd[i]);
        tick(2);
        bad_cmd = !((cmd == 8'h33) || (cmd == 8'h0F));
        chk({tag, "_cmd_valid_pulses"}, 64'(cmd_valid_cnt - c0), 64'd1);
        chk({tag, "_cmd_at_valid"}, 64'(valid_cmd), 64'(cmd));
        chk({tag, "_cmd_byte"}, 64'(cmd_byte), 64'(cmd));
        chk({tag, "_error"}, 64'(error), 64'(bad_cmd));
        chk({tag, "_busy"}, 64'(busy), 64'(!bad_cmd));
    endtask

    task automatic rom_check(input string tag);
        logic [63:0] r;
        int          bad, d0;
        d0 = rom_done_cnt;
        read_rom(64, r, bad);
        tick(3);
        chk({tag, "_rom"}, r, model_rom(FAMILY, serial));
        chk({tag, "_hold_widths"}, 64'(bad), 64'd0);
        chk({tag, "_rom_done_pulses"}, 64'(rom_done_cnt - d0), 64'd1);
        chk({tag, "_busy_halt"}, 64'(busy), 64'd0);
    endtask

    task automatic halt_check(input string tag, input int n);
        logic [63:0] r;
        int          bad, o0;
        o0 = oe_cnt;
        read_rom(n, r, bad);
        chk({tag, "_oe_cycles"}, 64'(oe_cnt - o0), 64'd0);
        chk({tag, "_reads_high"}, r, (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1));
    endtask

    initial begin
        logic [63:0] r;
        logic [7:0]  cmd;
        int          bad, p0, o0, k;

        reset = 1'b0;
        master_low = 1'b0;
        serial = '0;
        tick(5);
        chk("reset_outputs", 64'({dq_oe, presence, cmd_valid, cmd_byte, rom_done, busy, error}), 64'd0);
        reset = 1'b1;
        tick(5);

        // Sub-threshold lows and read slots while idle: no response at all.
        p0 = presence_cnt;
        o0 = oe_cnt;
        for (int i = 0; i < 3; i++) begin
            master_low = 1'b1;
            tick($urandom_range(360, 385));
            master_low = 1'b0;
            tick(150);
        end
        chk("idle_short_no_presence", 64'(presence_cnt - p0), 64'd0);
        chk("idle_short_no_oe", 64'(oe_cnt - o0), 64'd0);
        halt_check("idle_slots", 10);
        chk("idle_busy", 64'(busy), 64'd0);

        // Known DS2401-style ROM image.
        serial = 48'h000001B81C;
        presence_seq("t1");
        cmd_seq("t1", 8'h33);
        read_rom(64, r, bad);
        tick(3);
        chk("t1_rom_const", r, 64'hA2000000_01B81C02);
        chk("t1_rom_model", r, model_rom(FAMILY, serial));
        chk("t1_hold_widths", 64'(bad), 64'd0);
        chk("t1_rom_done_pulses", 64'(rom_done_cnt), 64'd1);
        halt_check("t1_halt", 8);

        // Alternate Read ROM opcode with a random serial.
        serial = {$urandom(), $urandom()};
        presence_seq("t2");
        cmd_seq("t2", 8'h0F);
        rom_check("t2");

        // Unsupported command: sticky error and silence for a full ROM's worth of slots.
        serial = {$urandom(), $urandom()};
        presence_seq("t3");
        cmd_seq("t3", 8'hF0);
        halt_check("t3_halt", 64);
        chk("t3_error_sticky", 64'(error), 64'd1);

        // Abort mid-ROM, reset twice, then a full clean read.
        serial = {$urandom(), $urandom()};
        presence_seq("t4a");
        cmd_seq("t4a", 8'h33);
        read_rom(20, r, bad);
        chk("t4_partial_rom", r & ((64'd1 << 20) - 64'd1),
            model_rom(FAMILY, serial) & ((64'd1 << 20) - 64'd1));
        presence_seq("t4_abort");
        presence_seq("t4_again");
        cmd_seq("t4b", 8'h33);
        rom_check("t4b");

        // Random sessions with a mix of commands.
        for (int s = 0; s < 2; s++) begin
            serial = {$urandom(), $urandom()};
            case ($urandom_range(0, 2))
                0:       cmd = 8'h33;
                1:       cmd = 8'h0F;
                default: cmd = 8'($urandom_range(0, 255));
            endcase
            presence_seq("rnd");
            cmd_seq("rnd", cmd);
            if ((cmd == 8'h33) || (cmd == 8'h0F)) rom_check("rnd");
            else halt_check("rnd_halt", 8);
        end

        // Asynchronous reset while driving a 0 bit.
        serial = {$urandom(), $urandom()};
        presence_seq("t6");
        cmd_seq("t6", 8'h33);
        master_low = 1'b1;
        k = 0;
        while (!dq_oe && k < 20) begin tick(); k++; end
        chk("t6_driving_before_reset", 64'(dq_oe), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_oe_drops_async", 64'(dq_oe), 64'd0);
        master_low = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
        chk("t6_outputs_after_reset",
            64'({dq_oe, presence, cmd_valid, cmd_byte, rom_done, busy, error}), 64'd0);
        halt_check("t6_idle_slots", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
